tl_burst_arbiter: RTL and testbench

TL_BURST_ARBITER -- requirements
Module: tl_burst_arbiter

---
 rtl/tl_burst_arbiter.sv | 147 ++++++++++++++
 tb/tb_tl_burst_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_burst_arbiter.sv
// rtl/tl_burst_arbiter.sv - TileLink burst-aware N:1 beat arbiter, grant held for a whole message.
// Round-robin arbitration with macro TL_BURST_ARB_RR_EN, fixed priority (lowest index) otherwise.
module tl_burst_arbiter #(
  parameter int IN_NUM     = 2,
  parameter int PAYLOAD_W  = 64,
  parameter int SIZE_W     = 4,
  parameter int DATA_BYTES = 8,
  parameter int CNT_W      = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [IN_NUM-1:0]                   inp_valid_i,
  output logic [IN_NUM-1:0]                   inp_ready_o,
  input  logic [IN_NUM-1:0][PAYLOAD_W-1:0]    inp_payload_i,
  input  logic [IN_NUM-1:0][SIZE_W-1:0]       inp_size_i,
  input  logic [IN_NUM-1:0]                   inp_has_data_i,
  output logic                                oup_valid_o,
  input  logic                                oup_ready_i,
  output logic [PAYLOAD_W-1:0]                oup_payload_o,
  output logic [$clog2(IN_NUM)-1:0]           oup_sel_o,
  output logic                                busy_o
);

  localparam int SEL_W = $clog2(IN_NUM);
  localparam int LG_DB = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_BURST} state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   rem_q;
  logic [SEL_W-1:0]   win_idx;
  logic               win_found;
  logic [SEL_W-1:0]   idle_sel;
  logic [SEL_W-1:0]   cur_sel;
  logic               hs;
  logic [CNT_W-1:0]   beats;
  int                 sh;

`ifdef TL_BURST_ARB_RR_EN
  logic [SEL_W-1:0]   ptr_q;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    if (int'(i) == IN_NUM - 1) return '0;
    return i + SEL_W'(1);
  endfunction

  // Search starts at the pointer and wraps, so the last completed requester goes to the back.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < IN_NUM; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % IN_NUM;
      if (!win_found && inp_valid_i[idx]) begin
        win_found = 1'b1;
        win_idx   = SEL_W'(idx);
      end
    end
  end

  assign idle_sel = ptr_q;
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      if (!win_found && inp_valid_i[i]) begin
        win_found = 1'b1;
        win_idx   = SEL_W'(i);
      end
    end
  end

  assign idle_sel = sel_q;
`endif

  // Only IDLE arbitrates; HOLD and BURST replay the frozen grant.
  always_comb begin
    if (state_q == ST_IDLE) cur_sel = win_found ? win_idx : idle_sel;
    else                    cur_sel = sel_q;
    oup_valid_o   = inp_valid_i[cur_sel];
    oup_payload_o = inp_payload_i[cur_sel];
    inp_ready_o   = '0;
    inp_ready_o[cur_sel] = oup_ready_i && ((state_q != ST_IDLE) || win_found);
  end

  assign oup_sel_o = cur_sel;
  assign busy_o    = (state_q != ST_IDLE);
  assign hs        = oup_valid_o && oup_ready_i;

  // Beat count of the message being started; only meaningful on its first beat.
  always_comb begin
    sh    = 0;
    beats = CNT_W'(1);
    if (inp_has_data_i[cur_sel] && (int'(inp_size_i[cur_sel]) > LG_DB)) begin
      sh    = int'(inp_size_i[cur_sel]) - LG_DB;
      beats = (sh >= CNT_W) ? '1 : (CNT_W'(1) << sh);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rem_q   <= '0;
`ifdef TL_BURST_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (state_q == ST_IDLE && win_found) sel_q <= win_idx;
          if (hs) begin
            if (beats > 1) begin
              state_q <= ST_BURST;
              rem_q   <= beats - CNT_W'(1);
            end else begin
              state_q <= ST_IDLE;
              rem_q   <= '0;
`ifdef TL_BURST_ARB_RR_EN
              ptr_q   <= next_idx(cur_sel);
`endif
            end
          end else if (state_q == ST_IDLE && win_found) begin
            state_q <= ST_HOLD;
          end
        end
        ST_BURST: begin
          if (hs) begin
            if (rem_q == 1) begin
              state_q <= ST_IDLE;
              rem_q   <= '0;
`ifdef TL_BURST_ARB_RR_EN
              ptr_q   <= next_idx(cur_sel);
`endif
            end else begin
              rem_q <= rem_q - CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_burst_arbiter.sv
// tb/tb_tl_burst_arbiter.sv - directed scoreboard bench for tl_burst_arbiter (2 requesters).
module tb_tl_burst_arbiter;
  localparam int IN_NUM     = 2;
  localparam int PAYLOAD_W  = 64;
  localparam int SIZE_W     = 4;
  localparam int DATA_BYTES = 8;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                               rst;
  logic [IN_NUM-1:0]                  inp_valid;
  logic [IN_NUM-1:0]                  inp_ready;
  logic [IN_NUM-1:0][PAYLOAD_W-1:0]   inp_payload;
  logic [IN_NUM-1:0][SIZE_W-1:0]      inp_size;
  logic [IN_NUM-1:0]                  inp_has_data;
  logic                               oup_valid;
  logic                               oup_ready;
  logic [PAYLOAD_W-1:0]               oup_payload;
  logic [0:0]                         oup_sel;
  logic                               busy;

  tl_burst_arbiter #(
    .IN_NUM(IN_NUM), .PAYLOAD_W(PAYLOAD_W), .SIZE_W(SIZE_W),
    .DATA_BYTES(DATA_BYTES), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .inp_valid_i(inp_valid), .inp_ready_o(inp_ready),
    .inp_payload_i(inp_payload), .inp_size_i(inp_size), .inp_has_data_i(inp_has_data),
    .oup_valid_o(oup_valid), .oup_ready_i(oup_ready),
    .oup_payload_o(oup_payload), .oup_sel_o(oup_sel), .busy_o(busy)
  );

  typedef struct {
    logic [0:0]  sel;
    logic [63:0] pay;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tid      = 0;
  int   src_on[2], src_beat[2], src_nbeats[2], src_msg[2], src_nmsg[2], gap_at[2], gap_cnt[2];
  logic [3:0] src_size[2];
  logic       src_hd[2];
  logic       rdy;

  function automatic logic [63:0] pay(int t, int i, int m, int b);
    return {32'h0, 8'(t), 8'(i), 8'(m), 8'(b)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL t%0d %s observed=%0h expected=%0h", tid, tag, obs, exp);
    end
  endtask

  task automatic src_setup(int i, int nmsg, int nbeats, logic [3:0] size, logic hd);
    src_on[i]     = 1;
    src_beat[i]   = 0;
    src_msg[i]    = 0;
    src_nmsg[i]   = nmsg;
    src_nbeats[i] = nbeats;
    src_size[i]   = size;
    src_hd[i]     = hd;
    gap_at[i]     = -1;
    gap_cnt[i]    = 0;
  endtask

  task automatic expect_msg(int i, int m, int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      exp_t e;
      e.sel = 1'(i);
      e.pay = pay(tid, i, m, b);
      sb.push_back(e);
    end
  endtask

  // Sizes and has_data are scrambled on non-first beats; the arbiter must ignore them.
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      logic v;
      v = (src_on[i] != 0);
      if (v && gap_cnt[i] > 0 && src_beat[i] == gap_at[i]) begin
        v = 1'b0;
        gap_cnt[i]--;
      end
      inp_valid[i]   = v;
      inp_payload[i] = pay(tid, i, src_msg[i], src_beat[i]);
      if (src_beat[i] == 0) begin
        inp_size[i]     = src_size[i];
        inp_has_data[i] = src_hd[i];
      end else begin
        inp_size[i]     = 4'($urandom);
        inp_has_data[i] = 1'($urandom);
      end
    end
    oup_ready = rdy;
  endtask

  task automatic cycle();
    @(negedge clk);
    if (oup_valid === 1'b1 && oup_ready === 1'b1) begin
      int s;
      s = int'(oup_sel);
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL t%0d sb_underflow observed=0 expected>0", tid);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("hs_sel", 64'(oup_sel), 64'(e.sel));
        chk("hs_payload", oup_payload, e.pay);
      end
      src_beat[s]++;
      if (src_beat[s] >= src_nbeats[s]) begin
        src_beat[s] = 0;
        src_msg[s]++;
        if (src_msg[s] >= src_nmsg[s]) src_on[s] = 0;
      end
    end
    drive();
    #1;
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 2; i++) begin
      src_on[i] = 0; src_beat[i] = 0; src_msg[i] = 0; src_nmsg[i] = 0; src_nbeats[i] = 1;
      gap_at[i] = -1; gap_cnt[i] = 0; src_size[i] = '0; src_hd[i] = 1'b0;
    end
    rdy = 1'b1;
    rst = 1'b1;
    drive();
    cycle();
    cycle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sel", 64'(oup_sel), 64'd0);
    chk("rst_valid", 64'(oup_valid), 64'd0);
    chk("rst_ready", 64'(inp_ready), 64'd0);
    rst = 1'b0;

    // single beat, no data
    tid = 1;
    src_setup(0, 1, 1, 4'd3, 1'b0);
    expect_msg(0, 0, 1);
    cycle();
    chk("single_valid", 64'(oup_valid), 64'd1);
    chk("single_ready", 64'(inp_ready), 64'b01);
    chk("single_busy_pre", 64'(busy), 64'd0);
    cycle();
    chk("single_busy_post", 64'(busy), 64'd0);
    chk("single_drain", 64'(sb.size()), 64'd0);

    // 8-beat burst from req1
    tid = 2;
    src_setup(1, 1, 8, 4'd6, 1'b1);
    expect_msg(1, 0, 8);
    cnt = 0;
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      cycle();
      if (busy === 1'b1) cnt++;
    end
    chk("burst_drain", 64'(sb.size()), 64'd0);
    chk("burst_busy_cycles", 64'(cnt), 64'd7);
    chk("burst_busy_end", 64'(busy), 64'd0);

    // contention with 2-beat messages
    tid = 3;
    src_setup(0, 2, 2, 4'd4, 1'b1);
    src_setup(1, 1, 2, 4'd4, 1'b1);
`ifdef TL_BURST_ARB_RR_EN
    expect_msg(0, 0, 2);
    expect_msg(1, 0, 2);
    expect_msg(0, 1, 2);
`else
    expect_msg(0, 0, 2);
    expect_msg(0, 1, 2);
    expect_msg(1, 0, 2);
`endif
    drain("contention_drain", 40);

    // backpressure: grant frozen on req0 while req1 arrives
    tid = 4;
    rdy = 1'b0;
    src_setup(0, 1, 1, 4'd3, 1'b1);
    expect_msg(0, 0, 1);
    expect_msg(1, 0, 1);
    cycle();
    chk("bp_sel0", 64'(oup_sel), 64'd0);
    chk("bp_busy0", 64'(busy), 64'd0);
    src_setup(1, 1, 1, 4'd3, 1'b1);
    cycle();
    chk("bp_sel1", 64'(oup_sel), 64'd0);
    chk("bp_busy1", 64'(busy), 64'd1);
    chk("bp_ready1", 64'(inp_ready), 64'd0);
    cycle();
    chk("bp_sel2", 64'(oup_sel), 64'd0);
    rdy = 1'b1;
    cycle();
    chk("bp_sel3", 64'(oup_sel), 64'd0);
    chk("bp_ready3", 64'(inp_ready), 64'b01);
    drain("bp_drain", 20);

    // mid-burst gap of 2 cycles on beat 3 of 4
    tid = 5;
    src_setup(0, 1, 4, 4'd5, 1'b1);
    gap_at[0]  = 2;
    gap_cnt[0] = 2;
    expect_msg(0, 0, 4);
    cnt = 0;
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      cycle();
      if (busy === 1'b1 && oup_valid === 1'b0) begin
        cnt++;
        chk("gap_sel", 64'(oup_sel), 64'd0);
      end
    end
    chk("gap_drain", 64'(sb.size()), 64'd0);
    chk("gap_cycles", 64'(cnt), 64'd2);

    // reset after beat 2 of an 8-beat burst
    tid = 6;
    src_setup(1, 1, 8, 4'd6, 1'b1);
    expect_msg(1, 0, 2);
    drain("rstmid_pre", 20);
    chk("rstmid_busy_pre", 64'(busy), 64'd1);
    src_on[1] = 0;
    rst = 1'b1;
    drive();
    cycle();
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_sel", 64'(oup_sel), 64'd0);
    chk("rstmid_valid", 64'(oup_valid), 64'd0);
    rst = 1'b0;
    tid = 7;
    src_setup(0, 1, 1, 4'd3, 1'b0);
    src_setup(1, 1, 1, 4'd3, 1'b0);
    expect_msg(0, 0, 1);
    expect_msg(1, 0, 1);
    drain("rstmid_ptr_drain", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
